// File: rtl/hamming74_serial_rx.sv
// Bit-serial Hamming(7,4) receiver: deframes start/7 bits/stop, corrects
// single-bit errors and presents the data nibble on a valid/ready output.
module hamming74_serial_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  logic       rx_bit,
    output logic [3:0] data_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] syndrome,
    output logic       err_corrected,
    output logic [7:0] err_count,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        STOP,
        DECODE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_reg;
    logic [2:0]  syn_calc;
    logic [3:0]  data_flip;
    logic [3:0]  data_fixed;
    logic        handshake;
    logic        load;

    // Syndrome over the received codeword; cw[6:3] are the data bits.
    always_comb begin
        syn_calc[2] = shift_reg[2] ^ shift_reg[5] ^ shift_reg[4] ^ shift_reg[3];
        syn_calc[1] = shift_reg[1] ^ shift_reg[6] ^ shift_reg[4] ^ shift_reg[3];
        syn_calc[0] = shift_reg[0] ^ shift_reg[6] ^ shift_reg[5] ^ shift_reg[3];
    end

    // Only data-bit positions matter for the output; parity-bit syndromes
    // leave the nibble untouched.
    always_comb begin
        data_flip = '0;
        case (syn_calc)
            3'b011:  data_flip = 4'b1000;
            3'b101:  data_flip = 4'b0100;
            3'b110:  data_flip = 4'b0010;
            3'b111:  data_flip = 4'b0001;
            default: data_flip = '0;
        endcase
        data_fixed = shift_reg[6:3] ^ data_flip;
    end

    always_comb begin
        handshake = out_valid & out_ready;
        load      = (state == DECODE) & (~out_valid | out_ready);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (sample_en && !rx_bit) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (sample_en && (bit_cnt == 3'd6)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (sample_en) begin
                    state_next = rx_bit ? DECODE : IDLE;
                end
            end
            DECODE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (state == IDLE && sample_en && !rx_bit) begin
            bit_cnt <= '0;
        end else if (state == SHIFT && sample_en) begin
            shift_reg <= {shift_reg[5:0], rx_bit};
            bit_cnt   <= bit_cnt + 3'd1;
        end
    end

    // A load in the handshake cycle keeps out_valid high with the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out      <= '0;
            syndrome      <= '0;
            err_corrected <= 1'b0;
            err_count     <= '0;
            out_valid     <= 1'b0;
        end else if (load) begin
            data_out      <= data_fixed;
            syndrome      <= syn_calc;
            err_corrected <= |syn_calc;
            out_valid     <= 1'b1;
            if ((|syn_calc) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state == STOP && sample_en && !rx_bit) begin
                frame_err <= 1'b1;
            end
            if (state == DECODE && !load) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: doc/hamming74_serial_rx.md
# hamming74_serial_rx

Bit-serial receiver and single-error-correcting decoder for Hamming(7,4) codewords. It is the receiving end of the codeword path: it deserializes a framed 7-bit codeword from a one-wire line, computes the syndrome, and corrects any single-bit error. It then presents the 4-bit data word on a valid/ready output. Error statistics are kept for the LED and 7-segment display logic.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sample_en` in 1: bit strobe; the line is sampled only on cycles where this is 1.
- `rx_bit` in 1: serial line. Idles at 1.
- `data_out` out 4: corrected data {d3,d2,d1,d0}.
- `out_valid` out 1: `data_out` is held and valid.
- `out_ready` in 1: consumer accepts the word.
- `syndrome` out 3: syndrome of the last decoded frame.
- `err_corrected` out 1: the last decoded frame had a nonzero syndrome.
- `err_count` out 8: corrected-frame count, saturating at 255.
- `frame_err` out 1: sticky; set when a stop bit was sampled as 0.
- `overrun` out 1: sticky; set when a frame was dropped because the output was occupied.

## Operation
- Codeword layout is cw[6:0] = {d3, d2, d1, d0, p2, p1, p0}, where:
  - p2 = d2^d1^d0
  - p1 = d3^d1^d0
  - p0 = d3^d2^d0
- Examples: data 1010 gives 1010101; data 0110 gives 0110011.
- Frame format, one bit per `sample_en` strobe:
  - start bit 0;
  - cw[6] first, down to cw[0];
  - stop bit 1.
- Syndrome bits:
  - s2 = cw[2]^cw[5]^cw[4]^cw[3]
  - s1 = cw[1]^cw[6]^cw[4]^cw[3]
  - s0 = cw[0]^cw[6]^cw[5]^cw[3]
- Syndrome-to-bit flip:
  - 011 → cw[6]
  - 101 → cw[5]
  - 110 → cw[4]
  - 111 → cw[3]
  - 100 → cw[2]
  - 010 → cw[1]
  - 001 → cw[0]
  - 000 → no change
- Double errors are miscorrected silently; detecting them is out of scope.
- FSM states:
  - IDLE: on strobe with `rx_bit`=0, clear the bit counter and go to SHIFT. Strobes with `rx_bit`=1 stay in IDLE.
  - SHIFT: on each strobe, shift `rx_bit` into the shift register MSB-first. After the 7th bit, go to STOP.
  - STOP: on strobe with `rx_bit`=1, go to DECODE. On strobe with `rx_bit`=0, set `frame_err`, discard the frame and go to IDLE.
  - DECODE: one cycle, no strobe needed. Compute syndrome and correct the codeword. If `out_valid`=0 or the output is handshaking this cycle, load the output registers. Otherwise set `overrun` and drop the frame. Go to IDLE.
- The output load in DECODE updates `data_out`, `syndrome` and `err_corrected` together, and sets `out_valid`=1.
- `err_count` increments only on a load with nonzero syndrome. It holds at 255.
- The output handshake completes when `out_valid` and `out_ready` are both 1 on a rising edge. `out_valid` then drops, unless DECODE reloads in the same cycle, in which case it stays 1 with the new word.
- `data_out`, `syndrome` and `err_corrected` hold their values after the handshake until the next load.
- `frame_err` and `overrun` clear only on reset.
- Strobes that arrive during DECODE are ignored. The transmitter guarantees at least one strobe period between frames.

## Timing
- Reset (asynchronous on `rst_n`=0) puts the FSM in IDLE with bit counter 0 and shift register 0. All outputs reset to 0.
- Reset mid-frame abandons the frame. No output, counter or flag changes except the clear to 0.
- The input is sampled on the rising edge where `sample_en`=1.
- Latency: `out_valid` rises on the edge one cycle after the edge that samples a valid stop bit.
- `out_valid` must not depend combinationally on `out_ready`.
- All outputs are registered.
- `sample_en` may be 1 on every cycle, giving a full-rate line.

## Test plan
- **Clean frame:** send 1010101 with `out_ready`=1. Expect `data_out`=1010, `syndrome`=000, `err_corrected`=0, `err_count`=0.
- **Single error in a data bit:** send 1000101 (expected 1010101). Expect `syndrome`=110, `data_out`=1010, `err_corrected`=1, `err_count`=1.
- **Single error in a parity bit:** send 0110010 (expected 0110011). Expect `syndrome`=001, `data_out`=0110.
- **Stall and overrun:** hold `out_ready`=0 and send two frames, 1010101 then 0110011. Expect `data_out` to stay 1010 and `overrun`=1. After `out_ready`=1, the handshake completes and `out_valid` falls to 0.
- **Stop-bit error:** send a frame with stop bit 0. Expect `frame_err`=1, no `out_valid`, and the FSM back in IDLE. The next good frame still decodes correctly.
- **Saturation and reset:**
  - 260 erroneous frames → `err_count`=255.
  - Assert `rst_n`=0 mid-SHIFT → all outputs 0.
  - A subsequent clean frame → decodes correctly.
